// File: rtl/audio_channel_sequencer.sv
// Shares one audio processing core between the left and right codec
// channels with round-robin arbitration and per-channel DAC delivery.
// Optional core-timeout bypass: define AUDIO_SEQ_TIMEOUT_EN.
module audio_channel_sequencer #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] adc_left_data,
    input  logic              adc_left_valid,
    output logic              adc_left_ready,
    input  logic [DATA_W-1:0] adc_right_data,
    input  logic              adc_right_valid,
    output logic              adc_right_ready,
    output logic              core_start,
    output logic [DATA_W-1:0] core_data,
    output logic              core_chan,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic [DATA_W-1:0] dac_left_data,
    output logic              dac_left_valid,
    input  logic              dac_left_ready,
    output logic [DATA_W-1:0] dac_right_data,
    output logic              dac_right_valid,
    input  logic              dac_right_ready,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUTPUT
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              chan_q, chan_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [DATA_W-1:0] dl_q, dl_d;
    logic [DATA_W-1:0] dr_q, dr_d;
    logic              grant_l, grant_r;
    logic              expire;
    logic [DATA_W-1:0] res_val;
    logic              dac_rdy;

`ifdef AUDIO_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;

    // core done on the limit cycle wins over the bypass
    assign expire = (state_q == WAIT) && !core_done &&
                    (cnt_q == CNT_W'(TIMEOUT - 1));

    // wait counter restarts on every ISSUE, flag is sticky
    always_comb begin
        cnt_d  = cnt_q;
        terr_d = terr_q | expire;
        if (state_q == ISSUE) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // timeout counter and sticky error register
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // round-robin grant; a tie goes to the channel not served last
    always_comb begin
        grant_l = 1'b0;
        grant_r = 1'b0;
        if (state_q == IDLE) begin
            if (adc_left_valid && (!adc_right_valid || last_q)) begin
                grant_l = 1'b1;
            end else if (adc_right_valid) begin
                grant_r = 1'b1;
            end
        end
    end

    assign adc_left_ready  = grant_l;
    assign adc_right_ready = grant_r;

    assign res_val = core_done ? core_result : sample_q;
    assign dac_rdy = chan_q ? dac_right_ready : dac_left_ready;

    // next-state logic for the sequencer FSM and its datapath
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        chan_d   = chan_q;
        sample_d = sample_q;
        dl_d     = dl_q;
        dr_d     = dr_q;
        unique case (state_q)
            IDLE: begin
                if (grant_l) begin
                    sample_d = adc_left_data;
                    chan_d   = 1'b0;
                    state_d  = ISSUE;
                end else if (grant_r) begin
                    sample_d = adc_right_data;
                    chan_d   = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (core_done || expire) begin
                    if (chan_q) begin
                        dr_d = res_val;
                    end else begin
                        dl_d = res_val;
                    end
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (dac_rdy) begin
                    last_d  = chan_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and datapath registers, reset takes priority
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            chan_q   <= 1'b0;
            sample_q <= '0;
            dl_q     <= '0;
            dr_q     <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            chan_q   <= chan_d;
            sample_q <= sample_d;
            dl_q     <= dl_d;
            dr_q     <= dr_d;
        end
    end

    assign core_start      = (state_q == ISSUE);
    assign core_data       = sample_q;
    assign core_chan       = chan_q;
    assign dac_left_data   = dl_q;
    assign dac_right_data  = dr_q;
    assign dac_left_valid  = (state_q == OUTPUT) && !chan_q;
    assign dac_right_valid = (state_q == OUTPUT) && chan_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_audio_channel_sequencer.sv
// Scoreboard bench for audio_channel_sequencer with a behavioural core.
// Timeout scenarios follow AUDIO_SEQ_TIMEOUT_EN (TIMEOUT = 8 here).
module tb_audio_channel_sequencer;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] adc_left_data, adc_right_data;
    logic          adc_left_valid, adc_right_valid;
    logic          adc_left_ready, adc_right_ready;
    logic          core_start, core_chan, core_done;
    logic [DW-1:0] core_data, core_result;
    logic [DW-1:0] dac_left_data, dac_right_data;
    logic          dac_left_valid, dac_right_valid;
    logic          dac_left_ready, dac_right_ready;
    logic          busy, timeout_err;

    always #10 clock = ~clock;

    audio_channel_sequencer #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .adc_left_data(adc_left_data), .adc_left_valid(adc_left_valid),
        .adc_left_ready(adc_left_ready),
        .adc_right_data(adc_right_data), .adc_right_valid(adc_right_valid),
        .adc_right_ready(adc_right_ready),
        .core_start(core_start), .core_data(core_data),
        .core_chan(core_chan), .core_done(core_done),
        .core_result(core_result),
        .dac_left_data(dac_left_data), .dac_left_valid(dac_left_valid),
        .dac_left_ready(dac_left_ready),
        .dac_right_data(dac_right_data), .dac_right_valid(dac_right_valid),
        .dac_right_ready(dac_right_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic          ch;
        logic [DW-1:0] data;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];
    logic          served[$];
    int            dac_cnt_l = 0;
    int            dac_cnt_r = 0;
    int            core_mode = 0;
    logic [DW-1:0] core_resp = '0;
    int            core_lat = 1;
    int            cd_cnt = 0;
    logic [DW-1:0] cd_val = '0;

    // 0: echo, 1: fixed response, 2: silent (expect timeout bypass)
    function automatic logic [DW-1:0] model_out(input logic [DW-1:0] s);
        if (core_mode == 1) return core_resp;
        return s;
    endfunction

    task automatic step();
        exp_t e;
        @(negedge clock);
        if (!reset) begin
            if (adc_left_valid && adc_left_ready) begin
                e.ch = 1'b0;
                e.data = model_out(adc_left_data);
                sb.push_back(e);
                served.push_back(1'b0);
            end
            if (adc_right_valid && adc_right_ready) begin
                e.ch = 1'b1;
                e.data = model_out(adc_right_data);
                sb.push_back(e);
                served.push_back(1'b1);
            end
            checks++;
            if (dac_left_valid && dac_right_valid) begin
                errors++;
                $display("FAIL both_dac_valid: got L=1 R=1 want one-hot");
            end
            if (dac_left_valid && dac_left_ready) begin
                dac_cnt_l++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL dac_left_unexpected: got %h want none",
                             dac_left_data);
                end else begin
                    e = sb.pop_front();
                    if (e.ch !== 1'b0 || dac_left_data !== e.data) begin
                        errors++;
                        $display("FAIL dac_left_data: got %h want ch%0d %h",
                                 dac_left_data, e.ch, e.data);
                    end
                end
            end
            if (dac_right_valid && dac_right_ready) begin
                dac_cnt_r++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL dac_right_unexpected: got %h want none",
                             dac_right_data);
                end else begin
                    e = sb.pop_front();
                    if (e.ch !== 1'b1 || dac_right_data !== e.data) begin
                        errors++;
                        $display("FAIL dac_right_data: got %h want ch%0d %h",
                                 dac_right_data, e.ch, e.data);
                    end
                end
            end
            if (core_start && core_mode != 2) begin
                cd_cnt = core_lat;
                cd_val = model_out(core_data);
            end
        end
        @(posedge clock);
        #1;
        core_done = 1'b0;
        if (cd_cnt > 0) begin
            cd_cnt--;
            if (cd_cnt == 0) begin
                core_done = 1'b1;
                core_result = cd_val;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        sb.delete();
        served.delete();
        cd_cnt = 0;
    endtask

    task automatic test_reset();
        adc_left_valid = 1'b0;
        adc_right_valid = 1'b0;
        adc_left_data = '0;
        adc_right_data = '0;
        dac_left_ready = 1'b1;
        dac_right_ready = 1'b1;
        core_done = 1'b0;
        core_result = '0;
        apply_reset();
        checks++;
        if ({busy, core_start, core_chan, dac_left_valid,
             dac_right_valid, timeout_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy, core_start, core_chan, dac_left_valid,
                      dac_right_valid, timeout_err});
        end
        checks++;
        if (core_data !== '0 || dac_left_data !== '0 ||
            dac_right_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h want 0",
                     core_data, dac_left_data, dac_right_data);
        end
        adc_left_valid = 1'b1;
        adc_right_valid = 1'b1;
        #1;
        checks++;
        if (adc_left_ready !== 1'b1 || adc_right_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_tie_grant: got L=%b R=%b want L=1 R=0",
                     adc_left_ready, adc_right_ready);
        end
        adc_left_valid = 1'b0;
        adc_right_valid = 1'b0;
    endtask

    task automatic test_single_left();
        int rc;
        int lc;
        rc = dac_cnt_r;
        lc = dac_cnt_l;
        core_mode = 1;
        core_resp = 32'h0000_4321;
        core_lat = 1;
        adc_left_data = 32'h0000_1234;
        adc_left_valid = 1'b1;
        step();
        adc_left_valid = 1'b0;
        checks++;
        if (core_start !== 1'b1 || core_chan !== 1'b0 ||
            core_data !== 32'h0000_1234) begin
            errors++;
            $display("FAIL single_issue: got s=%b c=%b d=%h want 1 0 1234",
                     core_start, core_chan, core_data);
        end
        step();
        checks++;
        if (dac_left_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_wait: got v=%b b=%b want 0 1",
                     dac_left_valid, busy);
        end
        step();
        checks++;
        if (dac_left_valid !== 1'b1 || dac_left_data !== 32'h0000_4321 ||
            dac_right_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_out: got v=%b d=%h rv=%b want 1 4321 0",
                     dac_left_valid, dac_left_data, dac_right_valid);
        end
        step();
        checks++;
        if (busy !== 1'b0 || dac_cnt_l != lc + 1 || dac_cnt_r != rc ||
            core_start !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got b=%b l=%0d r=%0d want 0 %0d %0d",
                     busy, dac_cnt_l, dac_cnt_r, lc + 1, rc);
        end
        checks++;
        if (dac_left_data !== 32'h0000_4321) begin
            errors++;
            $display("FAIL single_hold: got %h want 4321", dac_left_data);
        end
    endtask

    task automatic test_tie();
        int lc;
        int rc;
        int n;
        apply_reset();
        lc = dac_cnt_l;
        rc = dac_cnt_r;
        core_mode = 0;
        core_lat = 1;
        adc_left_data = 32'h11;
        adc_right_data = 32'h22;
        adc_left_valid = 1'b1;
        adc_right_valid = 1'b1;
        n = 0;
        while (served.size() < 4 && n < 40) begin
            step();
            n++;
        end
        adc_left_valid = 1'b0;
        adc_right_valid = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (served.size() != 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tie_count: got %0d busy=%b want 4 0",
                     served.size(), busy);
        end
        for (int i = 0; i < served.size() && i < 4; i++) begin
            checks++;
            if (served[i] !== i[0]) begin
                errors++;
                $display("FAIL tie_order[%0d]: got %b want %b",
                         i, served[i], i[0]);
            end
        end
        checks++;
        if (dac_cnt_l != lc + 2 || dac_cnt_r != rc + 2 || sb.size() != 0) begin
            errors++;
            $display("FAIL tie_deliver: got l=%0d r=%0d q=%0d want %0d %0d 0",
                     dac_cnt_l - lc, dac_cnt_r - rc, sb.size(), 2, 2);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int rc;
        logic bad;
        rc = dac_cnt_r;
        core_mode = 0;
        core_lat = 1;
        dac_right_ready = 1'b0;
        adc_right_data = 32'h5A5A_0001;
        adc_right_valid = 1'b1;
        step();
        adc_right_valid = 1'b0;
        n = 0;
        while (!dac_right_valid && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (dac_right_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid: got %b want 1", dac_right_valid);
        end
        adc_left_data = 32'h77;
        adc_left_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (dac_right_valid !== 1'b1 || dac_right_data !== 32'h5A5A_0001 ||
                adc_left_ready !== 1'b0 || adc_right_ready !== 1'b0) begin
                bad = 1'b1;
            end
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: got unstable/ready want held 5a5a0001");
        end
        adc_left_valid = 1'b0;
        dac_right_ready = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || dac_cnt_r != rc + 1) begin
            errors++;
            $display("FAIL bp_release: got b=%b n=%0d want 0 %0d",
                     busy, dac_cnt_r, rc + 1);
        end
    endtask

    task automatic test_reset_mid_wait();
        int lc;
        int rc;
        logic bad;
        core_mode = 2;
        adc_left_data = 32'h99;
        adc_left_valid = 1'b1;
        step();
        adc_left_valid = 1'b0;
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midwait_busy: got %b want 1", busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        cd_cnt = 0;
        checks++;
        if ({busy, core_start, core_chan, dac_left_valid, dac_right_valid}
                !== 5'b0 || core_data !== '0 || dac_left_data !== '0) begin
            errors++;
            $display("FAIL midwait_reset: got b=%b d=%h want 0 0",
                     busy, core_data);
        end
        lc = dac_cnt_l;
        rc = dac_cnt_r;
        core_result = 32'hDEAD;
        core_done = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (busy || dac_left_valid || dac_right_valid) bad = 1'b1;
        end
        checks++;
        if (bad || dac_cnt_l != lc || dac_cnt_r != rc) begin
            errors++;
            $display("FAIL midwait_stray_done: got activity want none");
        end
    endtask

`ifdef AUDIO_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int rc;
        apply_reset();
        core_mode = 2;
        adc_right_data = 32'h0000_ABCD;
        adc_right_valid = 1'b1;
        step();
        adc_right_valid = 1'b0;
        for (int k = 0; k < 8; k++) step();
        checks++;
        if (dac_right_valid !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL to_early: got v=%b e=%b want 0 0",
                     dac_right_valid, timeout_err);
        end
        step();
        checks++;
        if (dac_right_valid !== 1'b1 || dac_right_data !== 32'h0000_ABCD ||
            timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL to_fire: got v=%b d=%h e=%b want 1 abcd 1",
                     dac_right_valid, dac_right_data, timeout_err);
        end
        step();
        core_mode = 0;
        adc_left_data = 32'h55;
        adc_left_valid = 1'b1;
        step();
        adc_left_valid = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL to_sticky: got e=%b b=%b q=%0d want 1 0 0",
                     timeout_err, busy, sb.size());
        end
        apply_reset();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL to_reset: got %b want 0", timeout_err);
        end
        rc = dac_cnt_r;
        core_mode = 1;
        core_resp = 32'hBEEF;
        core_lat = 8;
        adc_right_data = 32'h1;
        adc_right_valid = 1'b1;
        step();
        adc_right_valid = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (timeout_err !== 1'b0 || dac_cnt_r != rc + 1 ||
            dac_right_data !== 32'hBEEF) begin
            errors++;
            $display("FAIL to_done_wins: got e=%b d=%h want 0 beef",
                     timeout_err, dac_right_data);
        end
        core_lat = 1;
    endtask
`else
    task automatic test_no_timeout();
        logic bad;
        apply_reset();
        core_mode = 2;
        adc_right_data = 32'h0000_ABCD;
        adc_right_valid = 1'b1;
        step();
        adc_right_valid = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (!busy || dac_left_valid || dac_right_valid || timeout_err) begin
                bad = 1'b1;
            end
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_timeout: got exit/flag want busy forever");
        end
        apply_reset();
    endtask
`endif

    initial begin
        reset = 1'b1;
        test_reset();
        test_single_left();
        test_tie();
        test_backpressure();
        test_reset_mid_wait();
`ifdef AUDIO_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
